// File: rtl/ps2_host_cmd_if.sv
// Command, receive and PS/2 line signals shared between the host sequencer and its user.
interface ps2_host_cmd_if;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       cmd_has_arg;
  logic [7:0] cmd_arg;
  logic       cmd_ready;
  logic       ps2clk;
  logic       ps2data;
  logic       ps2clk_drv_low;
  logic       ps2data_drv_low;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output cmd_valid, cmd_byte, cmd_has_arg, cmd_arg, ps2clk, ps2data, rx_byte, rx_valid,
    input  cmd_ready, ps2clk_drv_low, ps2data_drv_low, busy, done, err, err_code
  );

  modport slave (
    input  cmd_valid, cmd_byte, cmd_has_arg, cmd_arg, ps2clk, ps2data, rx_byte, rx_valid,
    output cmd_ready, ps2clk_drv_low, ps2data_drv_low, busy, done, err, err_code
  );
endinterface

// File: rtl/ps2_host_cmd.sv
// PS/2 host-to-device command sequencer: inhibit, request-to-send, frame transmit,
// response wait, with resend on 0xFE / missing line-ack and a per-phase timeout.
module ps2_host_cmd #(
  parameter int unsigned INHIBIT_CYC = 5000,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input logic           clk,
  input logic           reset,
  ps2_host_cmd_if.slave bus
);

  localparam int unsigned CntMax = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  // One spare code so the width stays non-zero and MAX_RETRY itself is representable.
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {StIdle, StInhibit, StRts, StSend, StWaitResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        cur_q, cur_d;
  logic [7:0]        arg_q, arg_d;
  logic              has_arg_q, has_arg_d;
  logic              phase_q, phase_d;  // 0: command byte in flight, 1: argument byte
  logic [RetryW-1:0] retry_q, retry_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [7:0]        samples_q;
  logic              fall, inhibit_end, timeout;
  logic              resend, fail;
  logic [1:0]        fail_code;

  assign fall        = (samples_q == 8'hF0);
  assign inhibit_end = (cnt_q == CntW'(INHIBIT_CYC - 1));
  // >= so an edge landing on the limit cycle cannot push the counter past it.
  assign timeout     = (cnt_q >= CntW'(TIMEOUT_CYC - 1));

  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;

  // Clock-line history for falling-edge detection (4 high then 4 low samples).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) samples_q <= 8'h00;
    else        samples_q <= {samples_q[6:0], bus.ps2clk};
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bitcnt_q   <= 4'd0;
      cur_q      <= 8'h00;
      arg_q      <= 8'h00;
      has_arg_q  <= 1'b0;
      phase_q    <= 1'b0;
      retry_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitcnt_q   <= bitcnt_d;
      cur_q      <= cur_d;
      arg_q      <= arg_d;
      has_arg_q  <= has_arg_d;
      phase_q    <= phase_d;
      retry_q    <= retry_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    bitcnt_d   = bitcnt_q;
    cur_d      = cur_q;
    arg_d      = arg_q;
    has_arg_d  = has_arg_q;
    phase_d    = phase_q;
    retry_d    = retry_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    resend     = 1'b0;
    fail       = 1'b0;
    fail_code  = 2'd0;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          cur_d     = bus.cmd_byte;
          arg_d     = bus.cmd_arg;
          has_arg_d = bus.cmd_has_arg;
          phase_d   = 1'b0;
          retry_d   = '0;
          state_d   = StInhibit;
        end
      end
      StInhibit: begin
        if (inhibit_end) state_d = StRts;
        else             cnt_d   = cnt_q + 1'b1;
      end
      StRts: begin
        bitcnt_d = 4'd0;
        state_d  = StSend;
      end
      StSend: begin
        cnt_d = cnt_q + 1'b1;
        if (fall) begin
          if (bitcnt_q == 4'd10) begin
            // Eleventh edge: device pulls data low to acknowledge the frame.
            if (!bus.ps2data) begin
              state_d = StWaitResp;
              cnt_d   = '0;
            end else begin
              resend = 1'b1;
            end
          end else begin
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end else if (timeout) begin
          fail      = 1'b1;
          fail_code = 2'd1;
        end
      end
      StWaitResp: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.rx_valid) begin
          if (bus.rx_byte == 8'hFA) begin
            if (!phase_q && has_arg_q) begin
              cur_d   = arg_q;
              phase_d = 1'b1;
              retry_d = '0;
              cnt_d   = '0;
              state_d = StInhibit;
            end else begin
              done_d  = 1'b1;
              state_d = StIdle;
            end
          end else if (bus.rx_byte == 8'hFE) begin
            resend = 1'b1;
          end else begin
            fail      = 1'b1;
            fail_code = 2'd3;
          end
        end else if (timeout) begin
          fail      = 1'b1;
          fail_code = 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (resend) begin
      if (retry_q < RetryW'(MAX_RETRY)) begin
        retry_d = retry_q + 1'b1;
        cnt_d   = '0;
        state_d = StInhibit;
      end else begin
        fail      = 1'b1;
        fail_code = 2'd2;
      end
    end

    if (fail) begin
      err_d      = 1'b1;
      err_code_d = fail_code;
      state_d    = StIdle;
    end
  end

  // Line drive and handshake outputs, decoded from the current state.
  always_comb begin
    bus.cmd_ready       = (state_q == StIdle);
    bus.busy            = (state_q != StIdle);
    bus.ps2clk_drv_low  = (state_q == StInhibit);
    bus.ps2data_drv_low = 1'b0;
    unique case (state_q)
      StRts: bus.ps2data_drv_low = 1'b1;
      StSend: begin
        if (bitcnt_q == 4'd0) begin
          bus.ps2data_drv_low = 1'b1;
        end else if (bitcnt_q <= 4'd8) begin
          // bitcnt 1..8 maps to cur[0..7]; 3-bit wrap turns 8 into index 7.
          bus.ps2data_drv_low = ~cur_q[bitcnt_q[2:0] - 3'd1];
        end else if (bitcnt_q == 4'd9) begin
          // Odd parity bit is ~^cur, so pulling low means ^cur.
          bus.ps2data_drv_low = ^cur_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_cmd.sv
// Bench for ps2_host_cmd: PS/2 device model on open-collector lines, table vectors,
// hand-written reset sequence and randomized transactions against a reference model.
module tb_ps2_host_cmd;

  localparam int unsigned InhibitCyc = 20;
  localparam int unsigned TimeoutCyc = 600;
  localparam int unsigned MaxRetry   = 3;
  localparam logic [8:0]  Nack       = 9'h100;  // device withholds the line-ack
  localparam logic [8:0]  NoResp     = 9'h1FF;  // line-ack but no response byte

  typedef struct packed {
    logic [7:0]      cmd;
    logic            has_arg;
    logic [7:0]      arg;
    logic            silent;
    int              nresp;
    logic [4:0][8:0] resp;
    int              reset_pulse;
    int              exp_frames;
    int              exp_done;
    int              exp_err;
    logic [1:0]      exp_code;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  int         cyc = 0;
  int         nchk = 0;
  int         nerr = 0;
  int         n_done = 0;
  int         n_err = 0;
  int         n_both = 0;
  int         err_cyc = 0;
  logic [1:0] last_code = 2'd0;
  logic [7:0] exp_q[$];
  int         m_done, m_err;
  logic [1:0] m_code;
  vec_t       tbl[9];

  ps2_host_cmd_if bus ();

  ps2_host_cmd #(
    .INHIBIT_CYC(InhibitCyc),
    .TIMEOUT_CYC(TimeoutCyc),
    .MAX_RETRY  (MaxRetry)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  assign bus.ps2clk  = ~(bus.ps2clk_drv_low | dev_clk_low);
  assign bus.ps2data = ~(bus.ps2data_drv_low | dev_data_low);

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      if (bus.done) n_done <= n_done + 1;
      if (bus.err) begin
        n_err     <= n_err + 1;
        last_code <= bus.err_code;
        err_cyc   <= cyc;
      end
      if (bus.done && bus.err) n_both <= n_both + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    nchk++;
    nerr++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic vec_t mkv(input logic [7:0] cmd, input logic has_arg, input logic [7:0] arg,
                               input logic silent, input int nresp, input logic [4:0][8:0] resp,
                               input int ef, input int ed, input int ee, input logic [1:0] ec);
    vec_t v;
    v = '0;
    v.cmd = cmd; v.has_arg = has_arg; v.arg = arg; v.silent = silent;
    v.nresp = nresp; v.resp = resp;
    v.exp_frames = ef; v.exp_done = ed; v.exp_err = ee; v.exp_code = ec;
    return v;
  endfunction

  // Protocol-level expectation: walk the device's reply list byte by byte.
  function automatic void model(input vec_t v);
    logic [7:0] b[2];
    logic [8:0] r;
    int stage, retry, ri, nb;
    exp_q.delete();
    m_done = 0; m_err = 0; m_code = 2'd0;
    if (v.silent) begin
      m_err = 1; m_code = 2'd1;
      return;
    end
    b[0] = v.cmd; b[1] = v.arg;
    nb = v.has_arg ? 2 : 1;
    stage = 0; retry = 0; ri = 0;
    while (1) begin
      exp_q.push_back(b[stage]);
      r = (ri < v.nresp) ? v.resp[ri] : NoResp;
      ri++;
      if (r == NoResp) begin
        m_err = 1; m_code = 2'd1;
        return;
      end
      if (r == Nack || r == 9'h0FE) begin
        if (retry < int'(MaxRetry)) begin
          retry++;
          continue;
        end
        m_err = 1; m_code = 2'd2;
        return;
      end
      if (r == 9'h0FA) begin
        if (stage < nb - 1) begin
          stage++;
          retry = 0;
        end else begin
          m_done = 1;
          return;
        end
      end else begin
        m_err = 1; m_code = 2'd3;
        return;
      end
    end
  endfunction

  task automatic run_txn(input vec_t v, input bit from_table);
    logic [9:0] bits;
    logic [8:0] r;
    logic [7:0] got;
    logic       exp_bit;
    int         ri, k, frames, d0, e0, b0, rts_cyc, ef, ed, ee;
    logic [1:0] ec;
    bit         fin;
    model(v);
    ef = from_table ? v.exp_frames : exp_q.size();
    ed = from_table ? v.exp_done : m_done;
    ee = from_table ? v.exp_err : m_err;
    ec = from_table ? v.exp_code : m_code;
    d0 = n_done; e0 = n_err; b0 = n_both;
    ri = 0; frames = 0; fin = 1'b0; rts_cyc = 0; bits = '0;
    @(negedge clk);
    check("ready_idle", bus.cmd_ready, 1);
    bus.cmd_byte = v.cmd; bus.cmd_has_arg = v.has_arg; bus.cmd_arg = v.arg;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("busy_accept", bus.busy, 1);
    while (!fin) begin
      k = 0;
      while (bus.busy && (bus.ps2clk_drv_low || !bus.ps2data_drv_low) && k < 5000) begin
        @(negedge clk);
        k++;
      end
      if (!bus.busy) begin
        fin = 1'b1;
      end else if (k >= 5000) begin
        bound_fail("rts_wait");
        fin = 1'b1;
      end else begin
        rts_cyc = cyc;
        check("start_bit", bus.ps2data, 0);
        if (v.silent) begin
          k = 0;
          while (bus.busy && k < 4 * int'(TimeoutCyc)) begin
            @(negedge clk);
            k++;
          end
          if (bus.busy) bound_fail("silent_wait");
          fin = 1'b1;
        end else begin
          r = (ri < v.nresp) ? v.resp[ri] : NoResp;
          ri++;
          // Stray command and receive strobe while busy must both be ignored.
          bus.cmd_valid = 1'b1; bus.cmd_byte = ~v.cmd;
          bus.rx_valid = 1'b1; bus.rx_byte = 8'hFA;
          @(negedge clk);
          bus.cmd_valid = 1'b0; bus.rx_valid = 1'b0;
          repeat (7) @(negedge clk);
          for (int p = 1; p <= 11; p++) begin
            if (p == 11 && r != Nack) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            repeat (8) @(negedge clk);
            if (p <= 10) bits[p-1] = bus.ps2data;
            if (p == v.reset_pulse) begin
              exp_bit = ~v.cmd[p-1];
              check("drv_before_reset", bus.ps2data_drv_low, exp_bit);
              reset = 1'b0;
              #1;
              check("rst_clk_drv", bus.ps2clk_drv_low, 0);
              check("rst_data_drv", bus.ps2data_drv_low, 0);
              check("rst_busy", bus.busy, 0);
              check("rst_ready", bus.cmd_ready, 1);
              check("rst_err_code", bus.err_code, 0);
              dev_clk_low = 1'b0; dev_data_low = 1'b0;
              repeat (3) @(negedge clk);
              reset = 1'b1;
              @(negedge clk);
              check("ready_after_reset", bus.cmd_ready, 1);
              return;
            end
            dev_clk_low = 1'b0;
            repeat (8) @(negedge clk);
            dev_data_low = 1'b0;
          end
          got = bits[7:0];
          frames++;
          check("parity_odd", ^bits[8:0], 1);
          check("stop_bit", bits[9], 1);
          if (frames <= exp_q.size())
            check($sformatf("frame%0d_byte", frames), got, exp_q[frames-1]);
          if (!r[8]) begin
            repeat (6) @(negedge clk);
            bus.rx_byte = r[7:0]; bus.rx_valid = 1'b1;
            @(negedge clk);
            bus.rx_valid = 1'b0;
          end
        end
      end
    end
    repeat (3) @(negedge clk);
    check("frames", frames, ef);
    check("done_pulses", n_done - d0, ed);
    check("err_pulses", n_err - e0, ee);
    if (ee != 0) check("err_code", last_code, ec);
    check("done_err_overlap", n_both - b0, 0);
    check("ready_end", bus.cmd_ready, 1);
    check("lines_released", {bus.ps2clk_drv_low, bus.ps2data_drv_low}, 0);
    if (v.silent) check("timeout_latency", err_cyc - rts_cyc, TimeoutCyc + 1);
  endtask

  initial begin
    vec_t rv;
    int   sel;
    logic [7:0] b;
    bus.cmd_valid = 1'b0; bus.cmd_byte = 8'h00; bus.cmd_has_arg = 1'b0; bus.cmd_arg = 8'h00;
    bus.rx_valid = 1'b0; bus.rx_byte = 8'h00;

    tbl[0] = mkv(8'hFF, 1'b0, 8'h00, 1'b0, 1, {9'h0, 9'h0, 9'h0, 9'h0, 9'h0FA}, 1, 1, 0, 2'd0);
    tbl[1] = mkv(8'hED, 1'b1, 8'h02, 1'b0, 2, {9'h0, 9'h0, 9'h0, 9'h0FA, 9'h0FA}, 2, 1, 0, 2'd0);
    tbl[2] = mkv(8'hF3, 1'b0, 8'h00, 1'b0, 3, {9'h0, 9'h0, 9'h0FA, 9'h0FE, 9'h0FE}, 3, 1, 0, 2'd0);
    tbl[3] = mkv(8'hF4, 1'b0, 8'h00, 1'b0, 4, {9'h0, 9'h0FE, 9'h0FE, 9'h0FE, 9'h0FE}, 4, 0, 1,
                 2'd2);
    tbl[4] = mkv(8'hEE, 1'b0, 8'h00, 1'b1, 0, '0, 0, 0, 1, 2'd1);
    tbl[5] = mkv(8'hF2, 1'b0, 8'h00, 1'b0, 2, {9'h0, 9'h0, 9'h0, 9'h0FA, Nack}, 2, 1, 0, 2'd0);
    tbl[6] = mkv(8'hF6, 1'b0, 8'h00, 1'b0, 0, '0, 1, 0, 1, 2'd1);
    tbl[7] = mkv(8'hF5, 1'b1, 8'h11, 1'b0, 1, {9'h0, 9'h0, 9'h0, 9'h0, 9'h0AB}, 1, 0, 1, 2'd3);
    tbl[8] = mkv(8'hED, 1'b1, 8'h07, 1'b0, 2, {9'h0, 9'h0, 9'h0, 9'h0FE, 9'h0FA}, 3, 0, 1,
                 2'd1);

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_ready", bus.cmd_ready, 1);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_err", bus.err, 0);
    check("reset_err_code", bus.err_code, 0);
    check("reset_drv", {bus.ps2clk_drv_low, bus.ps2data_drv_low}, 0);

    for (int i = 0; i < 9; i++) run_txn(tbl[i], 1'b1);

    // Reset during data bit 5, then a later command answered with a bogus byte.
    rv = mkv(8'hED, 1'b0, 8'h00, 1'b0, 1, {9'h0, 9'h0, 9'h0, 9'h0, 9'h0FA}, 0, 0, 0, 2'd0);
    rv.reset_pulse = 5;
    run_txn(rv, 1'b1);
    rv = mkv(8'hF0, 1'b0, 8'h00, 1'b0, 1, {9'h0, 9'h0, 9'h0, 9'h0, 9'h0AB}, 1, 0, 1, 2'd3);
    run_txn(rv, 1'b1);

    for (int i = 0; i < 12; i++) begin
      rv = '0;
      rv.cmd = 8'($urandom);
      rv.has_arg = 1'($urandom);
      rv.arg = 8'($urandom);
      rv.nresp = $urandom_range(1, 5);
      for (int j = 0; j < 5; j++) begin
        sel = $urandom_range(0, 19);
        if (sel < 10) rv.resp[j] = 9'h0FA;
        else if (sel < 15) rv.resp[j] = 9'h0FE;
        else if (sel < 17) rv.resp[j] = Nack;
        else begin
          b = 8'($urandom);
          if (b == 8'hFA || b == 8'hFE) b = 8'h00;
          rv.resp[j] = {1'b0, b};
        end
      end
      run_txn(rv, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/ps2_host_cmd.md
Name: ps2_host_cmd

Overview:
Host-to-device command sequencer for the PS/2 keyboard port. It takes a command byte and an optional argument byte (e.g. 0xED + LED mask, 0xFF reset), performs the PS/2 request-to-send and frame transmission on the open-collector lines, then waits for the device response on the raw-byte receive path. It retries on 0xFE and reports done or error. It sits beside the keyboard receiver and owns the bus while busy.

Parameters:
INHIBIT_CYC, 5000, clk cycles ps2clk is held low before RTS (100 us at 50 MHz)
TIMEOUT_CYC, 1000000, clk cycles allowed per frame and per response wait (20 ms at 50 MHz)
MAX_RETRY, 3, resends allowed per byte after 0xFE or missing line-ack

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  command request
cmd_byte  input  8  command byte
cmd_has_arg  input  1  an argument byte follows the command
cmd_arg  input  8  argument byte
cmd_ready  output  1  high in IDLE; a command is accepted when cmd_valid && cmd_ready
ps2clk  input  1  raw PS/2 clock line
ps2data  input  1  raw PS/2 data line
ps2clk_drv_low  output  1  1 = pull clock line low
ps2data_drv_low  output  1  1 = pull data line low
rx_byte  input  8  byte from the raw receiver
rx_valid  input  1  one-cycle strobe qualifying rx_byte
busy  output  1  high when not IDLE; receiver ignores traffic while busy
done  output  1  one-cycle pulse: sequence acknowledged
err  output  1  one-cycle pulse: sequence aborted
err_code  output  2  valid with err: 1 timeout, 2 retries exhausted, 3 unexpected response

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0 except cmd_ready=1; counters, retry count and err_code cleared. Reset mid-frame releases both lines immediately.
- Falling-edge detect: 8-sample shift of ps2clk; edge when samples[7:4]==4'hF and samples[3:0]==4'h0. Sampler resets to 0.
- IDLE: on accept, latch cmd_byte, cmd_has_arg and cmd_arg; cur=cmd_byte; retry=0; go to INHIBIT.
- INHIBIT: ps2clk_drv_low=1 for INHIBIT_CYC cycles, then go to RTS.
- RTS: ps2data_drv_low=1 (start bit), release clock for one cycle, then go to SEND with bitcnt=0 and the timeout counter cleared.
- SEND: on each falling edge bitcnt++. After edge n=1..8, drive data bit cur[n-1] (drv_low = ~bit). After edge 9, drive odd parity (~^cur). After edge 10, release data (stop bit). On edge 11, sample ps2data: 0 = line-ack, go to WAIT_RESP; 1 = resend path.
- WAIT_RESP: timeout counter cleared on entry.
  - rx_valid with 0xFA: if the command was just sent and an argument is pending, cur=arg, retry=0, go to INHIBIT; otherwise pulse done and go to IDLE.
  - rx_valid with 0xFE: resend path.
  - Any other rx_byte: err, code 3.
- Resend path: if retry<MAX_RETRY, retry++ and go to INHIBIT with the same cur; otherwise err, code 2.
- Timeout: the counter runs in SEND and WAIT_RESP. Reaching TIMEOUT_CYC gives err, code 1; both lines are released.
- On any err or done: release both lines, return to IDLE, cmd_ready=1 on the next cycle.
- cmd_valid while busy is ignored; no queueing.
- rx_valid outside WAIT_RESP is ignored.
- done and err are never asserted in the same cycle.

Test Plan:
- Send 0xFF, no arg. Device model line-acks and returns 0xFA. Required: bits on data = start 0, FF LSB-first, parity 1, stop; exactly one done pulse; cmd_ready back to 1.
- Send 0xED with arg 0x02. Device returns FA, FA. Required: two frames (ED then 02, parity 1 and 0); one done after the second FA.
- Send 0xF3. Device returns FE, FE, FA. Required: three identical frames, then done; err never asserted.
- Send 0xF4. Device returns FE four times with MAX_RETRY=3. Required: four frames total, then err with err_code=2.
- Send 0xEE. Device never clocks after RTS. Required: err with err_code=1 exactly TIMEOUT_CYC cycles after SEND entry; both drv outputs 0.
- Assert reset=0 during frame bit 5. Required: outputs reset immediately, lines released, IDLE with cmd_ready=1 after release; device replies 0xAB on a later command -> err_code=3.
